// File: rtl/fc_pkg.sv
// Shared constants and types for the fast-command transmit path.
// Parameters of fc_encoder default from the values defined here.
package fc_pkg;

    localparam int FC_WORD_W     = 8;
    localparam int FC_FIFO_DEPTH = 4;
    localparam int FC_ORBIT_LEN  = 3564;

    typedef logic [FC_WORD_W-1:0] fc_word_t;

    localparam fc_word_t FC_IDLE_WORD = 8'hAC;
    localparam fc_word_t FC_BCR_WORD  = 8'h2D;

endpackage

// File: rtl/fc_cmd_fifo.sv
// Register-based synchronous command FIFO with show-ahead read data.
// Writes while full and reads while empty are ignored.
module fc_cmd_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fc_encoder.sv
// Fast-command link transmitter: queues command words and serializes one word
// per bunch-crossing slot, MSB first. Optional macro FC_ORBIT_BCR_EN adds BCR insertion.
module fc_encoder
    import fc_pkg::*;
#(
    parameter int                WORD_W     = FC_WORD_W,
    parameter int                FIFO_DEPTH = FC_FIFO_DEPTH,
    parameter logic [WORD_W-1:0] IDLE_WORD  = FC_IDLE_WORD,
    parameter logic [WORD_W-1:0] BCR_WORD   = FC_BCR_WORD,
    parameter int                ORBIT_LEN  = FC_ORBIT_LEN
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [WORD_W-1:0]             cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          FC_invert,
    output logic                          FC_out,
    output logic                          word_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [11:0]                   bc_count
);

    localparam int              PH_W       = $clog2(WORD_W);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(WORD_W - 1);

    if (ORBIT_LEN < 2 || ORBIT_LEN > 4096) begin : g_orbit_len_check
        $error("ORBIT_LEN must lie within the 12-bit bc_count range");
    end

    logic [PH_W-1:0]   phase;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] fifo_head;
    logic [WORD_W-1:0] next_word;
    logic [11:0]       bc_next;
    logic              load_edge;
    logic              bcr_slot;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign load_edge  = (phase == LAST_PHASE);
    assign word_start = (phase == '0);
    assign FC_out     = shreg[WORD_W-1] ^ FC_invert;
    assign cmd_ready  = aresetn && !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_pop   = load_edge && !bcr_slot && !fifo_empty;

    fc_cmd_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (fifo_push),
        .wr_data (cmd_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Word selection for the next slot: BCR beats a queued command, which beats idle.
    always_comb begin
        bcr_slot = 1'b0;
        bc_next  = bc_count + 12'd1;
`ifdef FC_ORBIT_BCR_EN
        if (bc_count == 12'(ORBIT_LEN - 1)) begin
            bcr_slot = 1'b1;
            bc_next  = '0;
        end
`endif
        next_word = IDLE_WORD;
        if (bcr_slot) begin
            next_word = BCR_WORD;
        end else if (!fifo_empty) begin
            next_word = fifo_head;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            phase    <= '0;
            shreg    <= IDLE_WORD;
            bc_count <= '0;
        end else begin
            if (load_edge) begin
                phase    <= '0;
                shreg    <= next_word;
                bc_count <= bc_next;
            end else begin
                phase <= phase + 1'b1;
                shreg <= {shreg[WORD_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_fc_encoder.sv
// Directed self-checking bench for fc_encoder; define FC_ORBIT_BCR_EN on both
// the RTL and this bench to exercise BCR insertion with a 16-slot orbit.
module tb_fc_encoder;
    import fc_pkg::*;

`ifdef FC_ORBIT_BCR_EN
    localparam int ORBIT = 16;
`else
    localparam int ORBIT = 3564;
`endif

    logic        clk       = 1'b0;
    logic        aresetn   = 1'b0;
    logic [7:0]  cmd_data  = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        FC_invert = 1'b0;
    logic        cmd_ready;
    logic        FC_out;
    logic        word_start;
    logic [2:0]  fifo_level;
    logic [11:0] bc_count;

    int vecCount = 0;
    int missCount = 0;
    int tbPhase = 0;

    always #5 clk = ~clk;

    fc_encoder #(
        .ORBIT_LEN (ORBIT)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .FC_invert  (FC_invert),
        .FC_out     (FC_out),
        .word_start (word_start),
        .fifo_level (fifo_level),
        .bc_count   (bc_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic invert);
        cmd_valid = valid;
        cmd_data  = data;
        FC_invert = invert;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
        tbPhase = (tbPhase + 1) % 8;
    endtask

    // One serial bit of the current slot, then advance a cycle.
    task automatic checkBit(input logic [7:0] word, input string tag);
        checkOutput($sformatf("%s_bit%0d", tag, tbPhase), {31'd0, FC_out}, {31'd0, word[7-tbPhase]});
        checkOutput($sformatf("%s_ws%0d", tag, tbPhase), {31'd0, word_start}, {31'd0, tbPhase == 0});
        nextCycle();
    endtask

    task automatic checkSlot(input logic [7:0] word, input string tag);
        repeat (8) checkBit(word, tag);
    endtask

    task automatic doReset();
        aresetn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rst_ws", {31'd0, word_start}, 32'd1);
        checkOutput("rst_fc", {31'd0, FC_out}, 32'd1);
        checkOutput("rst_lvl", {29'd0, fifo_level}, 32'd0);
        checkOutput("rst_bc", {20'd0, bc_count}, 32'd0);
        aresetn = 1'b1;
        #1;
        tbPhase = 0;
        checkOutput("rel_ws", {31'd0, word_start}, 32'd1);
        checkOutput("rel_fc", {31'd0, FC_out}, 32'd1);
        checkOutput("rel_lvl", {29'd0, fifo_level}, 32'd0);
    endtask

`ifdef FC_ORBIT_BCR_EN
    task automatic runBcrTests();
        logic [7:0] pushData;
        logic [7:0] nextExp;
        logic [7:0] expWord;
        pushData = 8'h10;
        nextExp  = 8'h10;
        doReset();
        for (int s = 0; s < 34; s++) begin
            if (s == 0) begin
                expWord = 8'hAC;
            end else if (s % 16 == 0) begin
                expWord = 8'h2D;
            end else begin
                expWord = nextExp;
                nextExp = nextExp + 8'd1;
            end
            checkOutput($sformatf("bcr_bc_slot%0d", s), {20'd0, bc_count}, s % 16);
            for (int p = 0; p < 8; p++) begin
                applyStimulus(1'b1, pushData, 1'b0);
                if (cmd_ready) pushData = pushData + 8'd1;
                checkBit(expWord, $sformatf("bcr_slot%0d", s));
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask
`else
    task automatic runDefaultTests();
        logic [7:0] expWords [8];
        int pushIdx;

        doReset();
        checkSlot(8'hAC, "idle0");
        checkSlot(8'hAC, "idle1");
        checkOutput("bc_after2", {20'd0, bc_count}, 32'd2);
        checkOutput("ready_idle", {31'd0, cmd_ready}, 32'd1);

        // Single command pushed at phase 3 lands in the next slot.
        repeat (3) checkBit(8'hAC, "pre5a");
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkBit(8'hAC, "pre5a");
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("lvl_5a", {29'd0, fifo_level}, 32'd1);
        repeat (4) checkBit(8'hAC, "pre5a");
        checkOutput("lvl_5a_load", {29'd0, fifo_level}, 32'd0);
        checkSlot(8'h5A, "cmd5a");
        checkSlot(8'hAC, "post5a");

        // Six commands held on cmd_valid, FIFO fills and drains in order.
        expWords = '{8'hAC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hAC};
        pushIdx = 0;
        for (int s = 0; s < 8; s++) begin
            for (int p = 0; p < 8; p++) begin
                if (pushIdx < 6) applyStimulus(1'b1, 8'(pushIdx + 1), 1'b0);
                else             applyStimulus(1'b0, 8'h00, 1'b0);
                if (s == 0 && p == 4) begin
                    checkOutput("b2b_ready_full", {31'd0, cmd_ready}, 32'd0);
                    checkOutput("b2b_lvl_full", {29'd0, fifo_level}, 32'd4);
                end
                if (s == 1 && p == 0) begin
                    checkOutput("b2b_ready_back", {31'd0, cmd_ready}, 32'd1);
                    checkOutput("b2b_lvl_pop", {29'd0, fifo_level}, 32'd3);
                end
                if (cmd_valid && cmd_ready) pushIdx++;
                checkBit(expWords[s], $sformatf("b2b_slot%0d", s));
            end
        end
        checkOutput("b2b_pushed", pushIdx, 32'd6);
        checkOutput("b2b_lvl_end", {29'd0, fifo_level}, 32'd0);

        // Output inversion, whole word then from phase 4 onward.
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkSlot(8'h53, "inv_idle");
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (4) checkBit(8'hA3, "inv_mid");
        applyStimulus(1'b0, 8'h00, 1'b1);
        repeat (4) checkBit(8'hA3, "inv_mid");
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkSlot(8'hAC, "inv_off");

        // Reset at phase 5 with three words queued discards them.
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkBit(8'hAC, "rst_q");
        applyStimulus(1'b1, 8'h22, 1'b0);
        checkBit(8'hAC, "rst_q");
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkBit(8'hAC, "rst_q");
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkBit(8'hAC, "rst_q");
        checkBit(8'hAC, "rst_q");
        checkOutput("rst_q_phase", tbPhase, 32'd5);
        checkOutput("rst_q_lvl", {29'd0, fifo_level}, 32'd3);
        doReset();
        repeat (4) checkSlot(8'hAC, "rst_after");
        checkOutput("bc_after_rst", {20'd0, bc_count}, 32'd4);

        // bc_count free-runs modulo 4096.
        repeat (4092 * 8) nextCycle();
        checkOutput("bc_wrap", {20'd0, bc_count}, 32'd0);
        checkSlot(8'hAC, "wrap_idle");
        checkOutput("bc_wrap1", {20'd0, bc_count}, 32'd1);
    endtask
`endif

    initial begin
        @(negedge clk);
        #1;
`ifdef FC_ORBIT_BCR_EN
        runBcrTests();
`else
        runDefaultTests();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
